lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning memory read-settle cycles before rdata is sampled (legal range 1..15).
REQ-002 SHALL have port clk_i  in  1  system clock, single clock domain.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid_i  in  1  core request valid.
REQ-005 SHALL have port req_ready_o  out  1  LSU can accept a request.
REQ-006 SHALL have port req_we_i  in  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr_i  in  32  byte address.
REQ-008 SHALL have port req_wdata_i  in  32  store data, right-aligned.
REQ-009 SHALL have port req_size_i  in  2  size code: 00 word, 01 byte, 10 half, 11 illegal.
REQ-010 SHALL have port req_unsigned_i  in  1  zero-extend the load.
REQ-011 SHALL have port resp_valid_o  out  1  response valid.
REQ-012 SHALL have port resp_ready_i  in  1  core accepts the response.
REQ-013 SHALL have port resp_rdata_o  out  32  load data, already extended; 0 for stores and errors.
REQ-014 SHALL have port resp_err_o  out  1  misaligned or illegal-size request.
REQ-015 SHALL have ports mem_addr_o (out, 32), mem_wdata_o (out, 32), mem_we_o (out, 1), mem_hb_o (out, 2), mem_uload_o (out, 1) and mem_rdata_i (in, 32), forming the data-memory port; mem_hb_o uses the same encoding as req_size_i.

Function
REQ-016 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-017 SHALL drive req_ready_o=1 only in IDLE.
REQ-018 SHALL, on a handshake (valid & ready), register addr, wdata, we, size and unsigned.
REQ-019 SHALL compute misalignment as: size 00 with addr[1:0]!=0; size 10 with addr[0]=1; size 11 always.
REQ-020 SHALL, on an accepted misaligned request, go IDLE -> RESP without any memory access, with resp_err_o=1 and resp_rdata_o=0.
REQ-021 SHALL, on an accepted aligned request, go IDLE -> ACCESS, load wait counter to MEM_LAT-1, and drive mem_addr_o, mem_wdata_o, mem_hb_o and mem_uload_o from the registered fields for all ACCESS cycles.
REQ-022 SHALL, for a store, assert mem_we_o for exactly the first ACCESS cycle, then go to RESP the next cycle with rdata=0 (store latency: request accept to resp_valid = 2 cycles).
REQ-023 SHALL, for a load, hold mem_we_o=0, decrement the counter each ACCESS cycle, and when the counter is 0 capture mem_rdata_i into resp_rdata_o and go to RESP (load latency = MEM_LAT+1 cycles).
REQ-024 SHALL assert resp_valid_o in RESP, holding rdata and err stable until resp_ready_i=1, then return to IDLE.
REQ-025 SHALL NOT accept a new request in the same cycle the response is accepted (one outstanding transaction, no bypass).
REQ-026 SHALL, outside ACCESS, drive mem_we_o=0 and mem_hb_o=11 (no lanes), and hold mem_addr_o at its last value.
REQ-027 SHALL ignore req_* changes while not in IDLE.
REQ-028 SHALL let the 4-bit counter wrap never occur: it only loads in IDLE and stops at 0.

Reset
REQ-029 SHALL, while rst_i=1, immediately force state IDLE, req_ready_o=0, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, mem_we_o=0, mem_hb_o=11, mem_addr_o=0, mem_wdata_o=0, mem_uload_o=0 and counter=0.
REQ-030 SHALL raise req_ready_o in the first clk_i edge after rst_i deasserts.
REQ-031 SHALL, on reset mid-ACCESS, abort the transaction with no further mem_we_o pulse and no response.

Verification
REQ-032 SHALL be tested with: store word 0xDEADBEEF to 0x10, MEM_LAT=1 -> one mem_we_o pulse, mem_addr_o=0x10, mem_hb_o=00, resp_valid 2 cycles after accept, err=0.
REQ-033 SHALL be tested with: load byte signed from 0x13 where mem_rdata_i=0xFFFFFF80, MEM_LAT=3 -> mem_hb_o=01, uload=0, resp_rdata_o=0xFFFFFF80 4 cycles after accept.
REQ-034 SHALL be tested with: load half from 0x11 -> resp_err_o=1, rdata=0, mem_hb_o stays 11, mem_we_o never high.
REQ-035 SHALL be tested with: load word, resp_ready_i low for 5 cycles -> resp_valid_o and rdata held, req_ready_o=0 throughout, IDLE on the cycle after acceptance.
REQ-036 SHALL be tested with: rst_i asserted during the second ACCESS cycle of a load (MEM_LAT=3) -> outputs reach reset values immediately and no response is issued.
REQ-037 SHALL be tested with: back-to-back store then load with resp_ready_i=1 -> the second request is accepted exactly one cycle after the first response completes.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: one outstanding core request, alignment check, sized
// data-memory access with a fixed read-settle time, sign/zero-extended loads.
module lsu #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic [1:0]  mem_hb_o,
  output logic        mem_uload_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_NONE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_e;

  state_e state_q, state_d;

  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic [1:0]    mem_hb_q, mem_hb_d;
  logic          mem_uload_q, mem_uload_d;

  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic hs_c;
  logic misal_c;
  logic last_c;

  // Memory returns right-aligned data; only the extension happens here.
  function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] d,
                                             input logic [1:0]    sz,
                                             input logic          uns);
    logic [DW-1:0] r;
    case (sz)
      SZ_BYTE: r = uns ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      SZ_HALF: r = uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign hs_c   = req_valid_i & req_ready_q;
  assign last_c = (cnt_q == '0);

  always_comb begin : misalign
    misal_c = 1'b0;
    case (req_size_i)
      SZ_WORD: misal_c = (req_addr_i[1:0] != 2'b00);
      SZ_HALF: misal_c = req_addr_i[0];
      SZ_BYTE: misal_c = 1'b0;
      default: misal_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin : regs
    if (rst_i) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_hb_q     <= SZ_NONE;
      mem_uload_q  <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= SZ_NONE;
      uns_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_hb_q     <= mem_hb_d;
      mem_uload_q  <= mem_uload_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (hs_c) state_d = misal_c ? S_RESP : S_ACCESS;
      S_ACCESS: if (we_q || last_c) state_d = S_RESP;
      S_RESP:   if (resp_ready_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin : outputs
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_uload_d  = mem_uload_q;
    mem_we_d     = 1'b0;
    mem_hb_d     = SZ_NONE;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (hs_c) begin
          we_d         = req_we_i;
          size_d       = req_size_i;
          uns_d        = req_unsigned_i;
          resp_rdata_d = '0;
          resp_err_d   = misal_c;
          if (!misal_c) begin
            mem_addr_d  = req_addr_i;
            mem_wdata_d = req_wdata_i;
            mem_uload_d = req_unsigned_i;
            mem_hb_d    = req_size_i;
            mem_we_d    = req_we_i;
            cnt_d       = CW'(MEM_LAT - 1);
          end
        end
      end
      S_ACCESS: begin
        if (state_d == S_ACCESS) mem_hb_d = size_q;
        if (!we_q) begin
          if (last_c) resp_rdata_d = load_ext(mem_rdata_i, size_q, uns_q);
          else        cnt_d        = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_we_o     = mem_we_q;
  assign mem_hb_o     = mem_hb_q;
  assign mem_uload_o  = mem_uload_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: instance a (MEM_LAT=1) and b (MEM_LAT=3) share request fields;
// each accepted request pushes its expected response into a scoreboard queue.
module tb_lsu;

  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 3;
  localparam int TMO = 64;
  localparam logic [102:0] RST_SNAP = {3'b000, 96'h0, 1'b0, 2'b11, 1'b0};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          hs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld_a = 1'b0, vld_b = 1'b0;
  logic        rr_a = 1'b1, rr_b = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = '0, wdata = '0, mrdata = '0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;

  logic        rdy_a, rv_a, err_a, mwe_a, mul_a;
  logic [31:0] rd_a, maddr_a, mwd_a;
  logic [1:0]  mhb_a;
  logic        rdy_b, rv_b, err_b, mwe_b, mul_b;
  logic [31:0] rd_b, maddr_b, mwd_b;
  logic [1:0]  mhb_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  int          we_cnt[2] = '{0, 0};
  int          hb_cnt[2] = '{0, 0};
  logic [31:0] we_addr[2];
  logic [31:0] we_data[2];
  logic [1:0]  we_hb[2];
  logic [1:0]  hb_last[2];
  logic        ul_last[2];

  wire [102:0] snap_a = {rdy_a, rv_a, err_a, rd_a, maddr_a, mwd_a, mwe_a, mhb_a, mul_a};
  wire [102:0] snap_b = {rdy_b, rv_b, err_b, rd_b, maddr_b, mwd_b, mwe_b, mhb_b, mul_b};

  lsu #(.MEM_LAT(LAT_A)) u_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(vld_a), .req_ready_o(rdy_a), .req_we_i(we), .req_addr_i(addr),
    .req_wdata_i(wdata), .req_size_i(size), .req_unsigned_i(uns),
    .resp_valid_o(rv_a), .resp_ready_i(rr_a), .resp_rdata_o(rd_a), .resp_err_o(err_a),
    .mem_addr_o(maddr_a), .mem_wdata_o(mwd_a), .mem_we_o(mwe_a), .mem_hb_o(mhb_a),
    .mem_uload_o(mul_a), .mem_rdata_i(mrdata)
  );

  lsu #(.MEM_LAT(LAT_B)) u_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(vld_b), .req_ready_o(rdy_b), .req_we_i(we), .req_addr_i(addr),
    .req_wdata_i(wdata), .req_size_i(size), .req_unsigned_i(uns),
    .resp_valid_o(rv_b), .resp_ready_i(rr_b), .resp_rdata_o(rd_b), .resp_err_o(err_b),
    .mem_addr_o(maddr_b), .mem_wdata_o(mwd_b), .mem_we_o(mwe_b), .mem_hb_o(mhb_b),
    .mem_uload_o(mul_b), .mem_rdata_i(mrdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mwe_a) begin we_cnt[0]++; we_addr[0] = maddr_a; we_data[0] = mwd_a; we_hb[0] = mhb_a; end
    if (mhb_a != 2'b11) begin hb_cnt[0]++; hb_last[0] = mhb_a; ul_last[0] = mul_a; end
    if (mwe_b) begin we_cnt[1]++; we_addr[1] = maddr_b; we_data[1] = mwd_b; we_hb[1] = mhb_b; end
    if (mhb_b != 2'b11) begin hb_cnt[1]++; hb_last[1] = mhb_b; ul_last[1] = mul_b; end
  end

  function automatic logic rdy(input bit s);        return s ? rdy_b : rdy_a; endfunction
  function automatic logic rv(input bit s);         return s ? rv_b  : rv_a;  endfunction
  function automatic logic er(input bit s);         return s ? err_b : err_a; endfunction
  function automatic logic [31:0] rd(input bit s);  return s ? rd_b  : rd_a;  endfunction
  function automatic int lat_of(input bit s);       return s ? int'(LAT_B) : int'(LAT_A); endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input bit s, input logic v);
    if (s) vld_b = v; else vld_a = v;
  endtask

  task automatic drive_req(input bit s, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input logic u, input logic [31:0] mem);
    we = w; addr = a; wdata = d; size = sz; uns = u; mrdata = mem;
    set_valid(s, 1'b1);
  endtask

  // Waits for the handshake; hs is the cycle in which valid & ready were both high.
  task automatic wait_accept(input bit s, input logic [31:0] exp_rd, input logic exp_err,
                             input bit track, output int hs);
    int   n = 0;
    exp_t e;
    while (!rdy(s) && n < TMO) begin tick(); n++; end
    if (!rdy(s)) begin
      checks++; errors++;
      $display("FAIL accept_timeout[%0d]: req_ready=%b after %0d cycles, required 1", s, rdy(s), n);
      set_valid(s, 1'b0);
      hs = -1;
      return;
    end
    hs = cyc;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = exp_err ? 1 : (we ? 2 : lat_of(s) + 1);
    e.hs    = hs;
    tick();
    set_valid(s, 1'b0);
    if (track) sbq.push_back(e);
  endtask

  // Waits for resp_valid and compares against the scoreboard head; does not step past it.
  task automatic wait_resp(input bit s, output int rc);
    int   n = 0;
    exp_t e;
    while (!rv(s) && n < TMO) begin tick(); n++; end
    rc = cyc;
    checks++;
    if (!rv(s)) begin
      errors++;
      $display("FAIL resp_timeout[%0d]: resp_valid=%b after %0d cycles, required 1", s, rv(s), n);
      return;
    end
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL resp_unexpected[%0d]: response with empty scoreboard, rdata=%h", s, rd(s));
      return;
    end
    e = sbq.pop_front();
    if (rd(s) !== e.rdata) begin
      errors++; $display("FAIL resp_rdata[%0d]: got %h required %h", s, rd(s), e.rdata);
    end
    checks++;
    if (er(s) !== e.err) begin
      errors++; $display("FAIL resp_err[%0d]: got %b required %b", s, er(s), e.err);
    end
    checks++;
    if (cyc - e.hs != e.lat) begin
      errors++; $display("FAIL resp_latency[%0d]: got %0d required %0d", s, cyc - e.hs, e.lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vld_a = 1'b0; vld_b = 1'b0; rr_a = 1'b1; rr_b = 1'b1;
    repeat (3) tick();
    checks++;
    if (snap_a !== RST_SNAP) begin errors++; $display("FAIL reset_outputs_a: got %h required %h", snap_a, RST_SNAP); end
    checks++;
    if (snap_b !== RST_SNAP) begin errors++; $display("FAIL reset_outputs_b: got %h required %h", snap_b, RST_SNAP); end
    rst = 1'b0;
    #1;
    checks++;
    if (rdy_a !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b required 0", rdy_a); end
    tick();
    checks++;
    if (rdy_a !== 1'b1) begin errors++; $display("FAIL ready_after_reset_a: got %b required 1", rdy_a); end
    checks++;
    if (rdy_b !== 1'b1) begin errors++; $display("FAIL ready_after_reset_b: got %b required 1", rdy_b); end
  endtask

  task automatic test_store_word();
    int hs, rc;
    int w0 = we_cnt[0];
    drive_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0);
    wait_accept(1'b0, 32'h0, 1'b0, 1'b1, hs);
    wait_resp(1'b0, rc);
    tick();
    checks++;
    if (we_cnt[0] - w0 != 1) begin errors++; $display("FAIL store_we_pulses: got %0d required 1", we_cnt[0] - w0); end
    checks++;
    if (we_addr[0] !== 32'h10) begin errors++; $display("FAIL store_addr: got %h required 00000010", we_addr[0]); end
    checks++;
    if (we_hb[0] !== 2'b00) begin errors++; $display("FAIL store_hb: got %b required 00", we_hb[0]); end
    checks++;
    if (we_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL store_wdata: got %h required deadbeef", we_data[0]); end
    checks++;
    if (rv_a !== 1'b0 || rdy_a !== 1'b1) begin
      errors++; $display("FAIL store_idle: got valid=%b ready=%b required valid=0 ready=1", rv_a, rdy_a);
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] t_addr[5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h20};
    logic [1:0]  t_size[5] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
    logic        t_uns[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] t_mem[5]  = '{32'hFFFFFF80, 32'hFFFFFF80, 32'h00008001, 32'h00018001, 32'h12345678};
    logic [31:0] t_exp[5]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'h12345678};
    int w0 = we_cnt[1];
    for (int i = 0; i < 5; i++) begin
      int hs, rc;
      drive_req(1'b1, 1'b0, t_addr[i], 32'h0, t_size[i], t_uns[i], t_mem[i]);
      wait_accept(1'b1, t_exp[i], 1'b0, 1'b1, hs);
      addr = 32'hFFFFFFFC; size = 2'b11; we = 1'b1;
      wait_resp(1'b1, rc);
      checks++;
      if (hb_last[1] !== t_size[i]) begin errors++; $display("FAIL load_hb[%0d]: got %b required %b", i, hb_last[1], t_size[i]); end
      checks++;
      if (ul_last[1] !== t_uns[i]) begin errors++; $display("FAIL load_uload[%0d]: got %b required %b", i, ul_last[1], t_uns[i]); end
      checks++;
      if (maddr_b !== t_addr[i]) begin errors++; $display("FAIL load_addr_hold[%0d]: got %h required %h", i, maddr_b, t_addr[i]); end
      tick();
    end
    checks++;
    if (we_cnt[1] != w0) begin errors++; $display("FAIL load_we: got %0d pulses required 0", we_cnt[1] - w0); end
  endtask

  task automatic test_misaligned();
    logic [31:0] t_addr[4] = '{32'h11, 32'h12, 32'h00, 32'h13};
    logic [1:0]  t_size[4] = '{2'b10, 2'b00, 2'b11, 2'b00};
    logic        t_we[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      int hs, rc;
      int h0 = hb_cnt[0];
      int w0 = we_cnt[0];
      drive_req(1'b0, t_we[i], t_addr[i], 32'hA5A5A5A5, t_size[i], 1'b0, 32'hFFFFFFFF);
      wait_accept(1'b0, 32'h0, 1'b1, 1'b1, hs);
      wait_resp(1'b0, rc);
      tick();
      checks++;
      if (hb_cnt[0] != h0) begin errors++; $display("FAIL misal_hb[%0d]: %0d cycles with lanes, required 0", i, hb_cnt[0] - h0); end
      checks++;
      if (we_cnt[0] != w0) begin errors++; $display("FAIL misal_we[%0d]: %0d pulses, required 0", i, we_cnt[0] - w0); end
    end
  endtask

  task automatic test_backpressure();
    int hs, rc;
    rr_a = 1'b0;
    drive_req(1'b0, 1'b0, 32'h40, 32'h0, 2'b00, 1'b0, 32'hCAFEF00D);
    wait_accept(1'b0, 32'hCAFEF00D, 1'b0, 1'b1, hs);
    wait_resp(1'b0, rc);
    mrdata = 32'h0BADBAD0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (rv_a !== 1'b1 || rd_a !== 32'hCAFEF00D || rdy_a !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: got valid=%b rdata=%h ready=%b required 1 cafef00d 0", i, rv_a, rd_a, rdy_a);
      end
    end
    rr_a = 1'b1;
    tick();
    checks++;
    if (rv_a !== 1'b0 || rdy_a !== 1'b1) begin
      errors++; $display("FAIL hold_release: got valid=%b ready=%b required 0 1", rv_a, rdy_a);
    end
  endtask

  task automatic test_reset_mid_access();
    int hs;
    int w0 = we_cnt[1];
    int seen = 0;
    drive_req(1'b1, 1'b0, 32'h80, 32'h0, 2'b00, 1'b0, 32'h13579BDF);
    wait_accept(1'b1, 32'h0, 1'b0, 1'b0, hs);
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (snap_b !== RST_SNAP) begin errors++; $display("FAIL midreset_b: got %h required %h", snap_b, RST_SNAP); end
    checks++;
    if (snap_a !== RST_SNAP) begin errors++; $display("FAIL midreset_a: got %h required %h", snap_a, RST_SNAP); end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rv_b) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midreset_resp: %0d cycles of resp_valid, required 0", seen); end
    checks++;
    if (we_cnt[1] != w0) begin errors++; $display("FAIL midreset_we: %0d pulses, required 0", we_cnt[1] - w0); end
    checks++;
    if (rdy_b !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b required 1", rdy_b); end
  endtask

  task automatic test_back_to_back();
    int hs1, rc1, hs2, rc2;
    rr_a = 1'b1;
    drive_req(1'b0, 1'b1, 32'h100, 32'h11223344, 2'b00, 1'b0, 32'h0);
    wait_accept(1'b0, 32'h0, 1'b0, 1'b1, hs1);
    drive_req(1'b0, 1'b0, 32'h104, 32'h0, 2'b00, 1'b0, 32'h55667788);
    wait_resp(1'b0, rc1);
    tick();
    wait_accept(1'b0, 32'h55667788, 1'b0, 1'b1, hs2);
    checks++;
    if (hs2 != rc1 + 1) begin errors++; $display("FAIL b2b_accept: second accept %0d cycles after response, required 1", hs2 - rc1); end
    wait_resp(1'b0, rc2);
    tick();
    checks++;
    if (we_data[0] !== 32'h11223344) begin errors++; $display("FAIL b2b_wdata: got %h required 11223344", we_data[0]); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_ext();
    test_misaligned();
    test_backpressure();
    test_reset_mid_access();
    test_back_to_back();
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
